// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the three-requester, dual-port RAM arbiter.
//   ADDR_W / DATA_W : default RAM address and data widths
//   N_REQ           : requester count (0 = ifetch, 1 = data, 2 = loader)
//   req_id_t        : requester index type
//   tag_t           : per-port pipeline tag (read flag + owning requester)
//   next_id()       : modulo-N_REQ increment of a requester index
// ---------------------------------------------------------------------------
package ram_arb_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int N_REQ  = 3;

   typedef logic [1:0] req_id_t;

   localparam req_id_t REQ_IFETCH = 2'd0;
   localparam req_id_t REQ_DATA   = 2'd1;
   localparam req_id_t REQ_LOADER = 2'd2;

   typedef struct packed {
      logic    rd;
      req_id_t own;
   } tag_t;

   function automatic req_id_t next_id(input req_id_t id);
      return (id == req_id_t'(N_REQ - 1)) ? '0 : req_id_t'(id + 2'd1);
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Requester-side bus of the RAM arbiter, one lane per requester.
//   req       : access request, held until granted
//   req_we    : 1 = write, 0 = read
//   req_addr  : per-requester address
//   req_wdata : per-requester write data
//   gnt       : same-cycle acceptance
//   rvalid    : one-cycle pulse marking rdata valid
//   rdata     : read data
// Modports: master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
   parameter int N_REQ  = ram_arb_pkg::N_REQ,
   parameter int ADDR_W = ram_arb_pkg::ADDR_W,
   parameter int DATA_W = ram_arb_pkg::DATA_W
) ();

   logic [N_REQ-1:0]             req;
   logic [N_REQ-1:0]             req_we;
   logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]             gnt;
   logic [N_REQ-1:0]             rvalid;
   logic [N_REQ-1:0][DATA_W-1:0] rdata;

   modport master (
      output req, req_we, req_addr, req_wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Rotating two-winner selection. Walks the requesters starting at rr_ptr;
// the first active one wins RAM port 1, the next active one in the same walk
// is the port-2 candidate. That candidate is dropped (port 2 stays idle) when
// it touches the same address as the port-1 winner and either access is a
// write, so a read never races a write to the same word.
//   req, we, addr  : requester requests, direction, addresses
//   rr_ptr         : requester with highest priority this cycle
//   gnt            : one-hot-or-two grant vector
//   p1_vld, p1_id  : port-1 winner
//   p2_vld, p2_id  : port-2 winner
// ---------------------------------------------------------------------------
module rr_select
   import ram_arb_pkg::req_id_t;
   import ram_arb_pkg::next_id;
#(
   parameter int N_REQ  = ram_arb_pkg::N_REQ,
   parameter int ADDR_W = ram_arb_pkg::ADDR_W
) (
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ-1:0]             we,
   input  logic [N_REQ-1:0][ADDR_W-1:0] addr,
   input  req_id_t                      rr_ptr,
   output logic [N_REQ-1:0]             gnt,
   output logic                         p1_vld,
   output req_id_t                      p1_id,
   output logic                         p2_vld,
   output req_id_t                      p2_id
);

   // NOTE: every signal written in a combinational block gets a default on
   // entry; a path that leaves one unassigned would infer a latch.
   always_comb begin
      req_id_t idx;
      logic    seen2;
      gnt    = '0;
      p1_vld = 1'b0;
      p1_id  = '0;
      p2_vld = 1'b0;
      p2_id  = '0;
      seen2  = 1'b0;
      idx    = rr_ptr;
      for (int k = 0; k < N_REQ; k++) begin
         if (req[idx]) begin
            if (!p1_vld) begin
               p1_vld = 1'b1;
               p1_id  = idx;
            end else if (!seen2) begin
               seen2 = 1'b1;
               if (!((addr[idx] == addr[p1_id]) && (we[idx] || we[p1_id]))) begin
                  p2_vld = 1'b1;
                  p2_id  = idx;
               end
            end
         end
         idx = next_id(idx);
      end
      if (p1_vld) gnt[p1_id] = 1'b1;
      if (p2_vld) gnt[p2_id] = 1'b1;
   end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Arbitrates three requesters onto a dual-port RAM, up to two accesses per
// cycle. Grant in cycle N, registered RAM strobes in N+1, read data back on
// rvalid in N+2 (fixed latency). Writes complete at grant and never return
// rvalid.
//   clk, rst                  : clock, synchronous active-high reset
//   bus (slave)               : requester bus (req/gnt/rvalid/rdata ...)
//   write_en1/2, read_en1/2   : registered RAM port strobes
//   addr1/2, Data_in1/2       : registered RAM port address / write data
//   Data_out1/2               : RAM read data, valid one cycle after strobe
// ---------------------------------------------------------------------------
module ram_arbiter
   import ram_arb_pkg::req_id_t;
   import ram_arb_pkg::tag_t;
   import ram_arb_pkg::next_id;
#(
   parameter int ADDR_W = ram_arb_pkg::ADDR_W,
   parameter int DATA_W = ram_arb_pkg::DATA_W,
   parameter int N_REQ  = ram_arb_pkg::N_REQ
) (
   input  logic              clk,
   input  logic              rst,
   ram_arbiter_if.slave      bus,
   output logic              write_en1,
   output logic              read_en1,
   output logic [ADDR_W-1:0] addr1,
   output logic [DATA_W-1:0] Data_in1,
   output logic              write_en2,
   output logic              read_en2,
   output logic [ADDR_W-1:0] addr2,
   output logic [DATA_W-1:0] Data_in2,
   input  logic [DATA_W-1:0] Data_out1,
   input  logic [DATA_W-1:0] Data_out2
);

   typedef struct packed {
      logic              we;
      logic              re;
      req_id_t           own;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } port_cmd_t;

   req_id_t          rr_ptr_q, rr_ptr_d;
   port_cmd_t        p1_q, p1_d, p2_q, p2_d;   // RAM-facing stage (N+1)
   tag_t             t1_q, t1_d, t2_q, t2_d;   // data-return stage (N+2)

   logic [N_REQ-1:0] req_eff;
   logic [N_REQ-1:0] sel_gnt;
   logic             sel_p1_vld, sel_p2_vld;
   req_id_t          sel_p1_id, sel_p2_id;

   // Requests are masked during reset so nothing is granted or registered.
   assign req_eff = rst ? '0 : bus.req;

   rr_select #(
      .N_REQ  (N_REQ),
      .ADDR_W (ADDR_W)
   ) u_rr_select (
      .req    (req_eff),
      .we     (bus.req_we),
      .addr   (bus.req_addr),
      .rr_ptr (rr_ptr_q),
      .gnt    (sel_gnt),
      .p1_vld (sel_p1_vld),
      .p1_id  (sel_p1_id),
      .p2_vld (sel_p2_vld),
      .p2_id  (sel_p2_id)
   );

   assign bus.gnt = sel_gnt;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      p1_d     = '0;
      p2_d     = '0;
      if (sel_p1_vld) begin
         p1_d.we   = bus.req_we[sel_p1_id];
         p1_d.re   = ~bus.req_we[sel_p1_id];
         p1_d.own  = sel_p1_id;
         p1_d.addr = bus.req_addr[sel_p1_id];
         p1_d.data = bus.req_we[sel_p1_id] ? bus.req_wdata[sel_p1_id] : '0;
      end
      if (sel_p2_vld) begin
         p2_d.we   = bus.req_we[sel_p2_id];
         p2_d.re   = ~bus.req_we[sel_p2_id];
         p2_d.own  = sel_p2_id;
         p2_d.addr = bus.req_addr[sel_p2_id];
         p2_d.data = bus.req_we[sel_p2_id] ? bus.req_wdata[sel_p2_id] : '0;
      end
      // Rotation restarts just past the lowest-priority winner this cycle.
      if (sel_p2_vld)      rr_ptr_d = next_id(sel_p2_id);
      else if (sel_p1_vld) rr_ptr_d = next_id(sel_p1_id);
      // Read tags follow the strobe one stage so they line up with Data_out.
      t1_d = '{rd: p1_q.re, own: p1_q.own};
      t2_d = '{rd: p2_q.re, own: p2_q.own};
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // its inputs as they were before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         t1_q     <= '0;
         t2_q     <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         t1_q     <= t1_d;
         t2_q     <= t2_d;
      end
   end

   // Port outputs are forced idle while reset is high, including the cycle
   // before the first reset edge clears the registers.
   assign write_en1 = p1_q.we & ~rst;
   assign read_en1  = p1_q.re & ~rst;
   assign addr1     = rst ? '0 : p1_q.addr;
   assign Data_in1  = rst ? '0 : p1_q.data;
   assign write_en2 = p2_q.we & ~rst;
   assign read_en2  = p2_q.re & ~rst;
   assign addr2     = rst ? '0 : p2_q.addr;
   assign Data_in2  = rst ? '0 : p2_q.data;

   // Route each port's returning data to the requester named in its tag.
   always_comb begin
      bus.rvalid = '0;
      bus.rdata  = '0;
      if (!rst) begin
         if (t1_q.rd) begin
            bus.rvalid[t1_q.own] = 1'b1;
            bus.rdata[t1_q.own]  = Data_out1;
         end
         if (t2_q.rd) begin
            bus.rvalid[t2_q.own] = 1'b1;
            bus.rdata[t2_q.own]  = Data_out2;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter with a behavioural dual-port RAM. RAM word a
// starts as 16'h1000 + a. Reads push {data, due cycle} into per-requester
// queues; a monitor pops and compares whenever rvalid is seen.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   localparam int AW = ADDR_W;
   localparam int DW = DATA_W;
   localparam int NR = N_REQ;

   logic          clk;
   logic          rst;
   logic          write_en1, read_en1, write_en2, read_en2;
   logic [AW-1:0] addr1, addr2;
   logic [DW-1:0] Data_in1, Data_in2;
   logic [DW-1:0] Data_out1, Data_out2;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t exp_q [NR][$];

   ram_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(NR)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .write_en1 (write_en1),
      .read_en1  (read_en1),
      .addr1     (addr1),
      .Data_in1  (Data_in1),
      .write_en2 (write_en2),
      .read_en2  (read_en2),
      .addr2     (addr2),
      .Data_in2  (Data_in2),
      .Data_out1 (Data_out1),
      .Data_out2 (Data_out2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAM: one-cycle read latency, writes land on the strobe edge.
   initial begin
      for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(16'h1000 + a);
      Data_out1 = '0;
      Data_out2 = '0;
      forever begin
         @(posedge clk);
         if (read_en1)  Data_out1 = mem[addr1];
         if (read_en2)  Data_out2 = mem[addr2];
         if (write_en1) mem[addr1] = Data_in1;
         if (write_en2) mem[addr2] = Data_in2;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic drive(input logic [2:0] r, input logic [2:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
      bus.req       = r;
      bus.req_we    = we;
      bus.req_addr  = {a2, a1, a0};
      bus.req_wdata = {d2, d1, d0};
   endtask

   task automatic idle();
      drive(3'b000, 3'b000, '0, '0, '0, '0, '0, '0);
   endtask

   task automatic expect_read(input int id, input logic [DW-1:0] data);
      exp_t e;
      e.data = data;
      e.due  = cyc + 2;
      exp_q[id].push_back(e);
   endtask

   // {we, re, addr} of each port packed for one-line comparisons.
   function automatic logic [31:0] port1();
      return 32'({write_en1, read_en1, addr1});
   endfunction

   function automatic logic [31:0] port2();
      return 32'({write_en2, read_en2, addr2});
   endfunction

   function automatic logic [31:0] pcmd(input logic we, input logic re, input logic [AW-1:0] a);
      return 32'({we, re, a});
   endfunction

   // Monitor: every rvalid must match the oldest expected read of that lane,
   // on exactly the due cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         for (int i = 0; i < NR; i++) begin
            if (bus.rvalid[i]) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("spurious_rvalid[%0d]", i), 32'd1, 32'd0);
               end else begin
                  e = exp_q[i].pop_front();
                  check($sformatf("rdata[%0d]", i), 32'(bus.rdata[i]), 32'(e.data));
                  check($sformatf("rvalid_cycle[%0d]", i), 32'(cyc), 32'(e.due));
               end
            end else if (exp_q[i].size() != 0 && exp_q[i][0].due <= cyc) begin
               e = exp_q[i].pop_front();
               check($sformatf("missing_rvalid[%0d]", i), 32'd0, 32'd1);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);

      // Reset: requests present but nothing granted, ports idle.
      @(negedge clk);
      drive(3'b111, 3'b000, 9'd1, 9'd2, 9'd3, '0, '0, '0);
      #1;
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_port1", port1(), 32'd0);
      check("rst_port2", port2(), 32'd0);
      check("rst_data_in", 32'({Data_in1, Data_in2}), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();

      // Single read by R0 at addr 1.
      @(negedge clk);
      drive(3'b001, 3'b000, 9'd1, '0, '0, '0, '0, '0);
      #1;
      check("r0_read_gnt", 32'(bus.gnt), 32'b001);
      expect_read(0, 16'h1001);
      @(negedge clk);
      idle();
      #1;
      check("r0_read_port1", port1(), pcmd(1'b0, 1'b1, 9'd1));
      check("r0_read_port2", port2(), 32'd0);

      // R2 write alone; moves rr_ptr back to 0.
      @(negedge clk);
      drive(3'b100, 3'b100, '0, '0, 9'd20, '0, '0, 16'hABCD);
      #1;
      check("r2_write_gnt", 32'(bus.gnt), 32'b100);

      // All three read for three cycles: {0,1}, {2,0}, {1,2}.
      @(negedge clk);
      drive(3'b111, 3'b000, 9'd10, 9'd11, 9'd12, '0, '0, '0);
      #1;
      check("rot_gnt_a", 32'(bus.gnt), 32'b011);
      check("r2_write_port1", 32'({port1(), 16'(Data_in1)}), 32'({pcmd(1'b1, 1'b0, 9'd20), 16'hABCD}));
      expect_read(0, 16'h100A);
      expect_read(1, 16'h100B);
      @(negedge clk);
      #1;
      check("rot_gnt_b", 32'(bus.gnt), 32'b101);
      check("rot_a_port1", port1(), pcmd(1'b0, 1'b1, 9'd10));
      check("rot_a_port2", port2(), pcmd(1'b0, 1'b1, 9'd11));
      expect_read(2, 16'h100C);
      expect_read(0, 16'h100A);
      @(negedge clk);
      #1;
      check("rot_gnt_c", 32'(bus.gnt), 32'b110);
      check("rot_b_port1", port1(), pcmd(1'b0, 1'b1, 9'd12));
      check("rot_b_port2", port2(), pcmd(1'b0, 1'b1, 9'd10));
      expect_read(1, 16'h100B);
      expect_read(2, 16'h100C);
      @(negedge clk);
      idle();
      #1;
      check("rot_c_port1", port1(), pcmd(1'b0, 1'b1, 9'd11));
      check("rot_c_port2", port2(), pcmd(1'b0, 1'b1, 9'd12));

      // Same-address write/read: only R0 (write 7 to addr 4), then R1 reads 7.
      @(negedge clk);
      drive(3'b011, 3'b001, 9'd4, 9'd4, '0, 16'd7, '0, '0);
      #1;
      check("hazard_gnt", 32'(bus.gnt), 32'b001);
      @(negedge clk);
      drive(3'b010, 3'b000, '0, 9'd4, '0, '0, '0, '0);
      #1;
      check("hazard_retry_gnt", 32'(bus.gnt), 32'b010);
      check("hazard_write_port1", 32'({port1(), 16'(Data_in1)}), 32'({pcmd(1'b1, 1'b0, 9'd4), 16'd7}));
      check("hazard_port2_idle", port2(), 32'd0);
      expect_read(1, 16'd7);
      @(negedge clk);
      idle();

      // R2 writes addr 6 on port 1 while R1 reads addr 5 on port 2.
      @(negedge clk);
      drive(3'b110, 3'b100, '0, 9'd5, 9'd6, '0, '0, 16'h0BEE);
      #1;
      check("split_gnt", 32'(bus.gnt), 32'b110);
      expect_read(1, 16'h1005);
      @(negedge clk);
      idle();
      #1;
      check("split_port1", 32'({port1(), 16'(Data_in1)}), 32'({pcmd(1'b1, 1'b0, 9'd6), 16'h0BEE}));
      check("split_port2", port2(), pcmd(1'b0, 1'b1, 9'd5));
      @(negedge clk);
      #1;
      check("split_rvalid", 32'(bus.rvalid), 32'b010);

      // Reset one cycle after a read grant discards the read.
      @(negedge clk);
      drive(3'b001, 3'b000, 9'd2, '0, '0, '0, '0, '0);
      #1;
      check("abort_gnt", 32'(bus.gnt), 32'b001);
      @(negedge clk);
      idle();
      rst = 1'b1;
      #1;
      check("abort_rst_ports", 32'({port1(), port2()}), 32'd0);
      check("abort_rst_rvalid", 32'(bus.rvalid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_ports_idle", 32'({port1(), port2()}), 32'd0);
      repeat (3) begin
         @(negedge clk);
         #1;
         check("abort_no_rvalid", 32'(bus.rvalid), 32'd0);
      end

      // rr_ptr restarted at 0 after reset.
      @(negedge clk);
      drive(3'b111, 3'b000, 9'd30, 9'd31, 9'd32, '0, '0, '0);
      #1;
      check("post_rst_gnt", 32'(bus.gnt), 32'b011);
      expect_read(0, 16'h101E);
      expect_read(1, 16'h101F);

      // R0 writes FFFF to addr 9; R2 reads it two cycles later.
      @(negedge clk);
      drive(3'b001, 3'b001, 9'd9, '0, '0, 16'hFFFF, '0, '0);
      #1;
      check("wr9_gnt", 32'(bus.gnt), 32'b001);
      @(negedge clk);
      idle();
      @(negedge clk);
      drive(3'b100, 3'b000, '0, '0, 9'd9, '0, '0, '0);
      #1;
      check("rd9_gnt", 32'(bus.gnt), 32'b100);
      expect_read(2, 16'hFFFF);
      @(negedge clk);
      idle();

      repeat (5) @(negedge clk);
      #3;
      for (int i = 0; i < NR; i++)
         check($sformatf("pending_reads[%0d]", i), 32'(exp_q[i].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
